// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states, memory size default
// and the request legality check used at acceptance.
package lsu_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 512;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // Reserved size, misalignment or out-of-range address rejects the access.
  function automatic logic req_error(input size_e size, input logic [31:0] addr,
                                     input int unsigned mem_bytes);
    logic bad;
    case (size)
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = |addr[1:0];
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad | (addr >= mem_bytes);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU request/response bus and word-wide memory bus of the load/store unit.
// Both are level signals; the CPU side handshakes with ReqValid/ReqReady only.
interface lsu_cpu_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RespValid;
  logic [31:0] RespRData;
  logic        RespErr;

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData,
    input  ReqReady, RespValid, RespRData, RespErr
  );
  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData,
    output ReqReady, RespValid, RespRData, RespErr
  );
endinterface

interface lsu_mem_if;
  logic        MemRD;
  logic        MemWR;
  logic [31:0] MemAddr;
  logic [31:0] MemDataOut;
  logic [31:0] MemDataIn;

  modport master (
    output MemRD, MemWR, MemAddr, MemDataOut,
    input  MemDataIn
  );
  modport slave (
    input  MemRD, MemWR, MemAddr, MemDataOut,
    output MemDataIn
  );
endinterface

// File: rtl/lsu_align.sv
// Big-endian lane logic: load extraction with sign/zero extension and sub-word store merge.
// Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word_i,
  input  logic [15:0] wdata_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic        signed_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] byte_word;
  logic [31:0] half_word;
  logic [31:0] mask;
  logic [31:0] ins;

  // Offset 0 is the most significant lane, so shift counts run downward.
  assign byte_sh   = {~off_i, 3'b000};
  assign half_sh   = off_i[1] ? 5'd0 : 5'd16;
  assign byte_word = rd_word_i >> byte_sh;
  assign half_word = rd_word_i >> half_sh;

  always_comb begin
    load_data_o = rd_word_i;
    mask        = 32'hFFFF_FFFF;
    ins         = 32'h0;
    case (size_i)
      SZ_BYTE: begin
        load_data_o = {{24{signed_i & byte_word[7]}}, byte_word[7:0]};
        mask        = 32'h0000_00FF << byte_sh;
        ins         = {24'h0, wdata_i[7:0]} << byte_sh;
      end
      SZ_HALF: begin
        load_data_o = {{16{signed_i & half_word[15]}}, half_word[15:0]};
        mask        = 32'h0000_FFFF << half_sh;
        ins         = {16'h0, wdata_i} << half_sh;
      end
      default: begin
        load_data_o = rd_word_i;
      end
    endcase
    merged_o = (rd_word_i & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: load 2 cycles, word store 2, sub-word store 3 (RMW), error 1.
// ReqReady only in IDLE; requests arriving while busy are ignored, responses cannot be stalled.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic      CLK,
  input  logic      Reset,
  lsu_cpu_if.slave  cpu,
  lsu_mem_if.master mem
);

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  size_e       size_q, size_d;
  logic        signed_q, signed_d;
  logic        write_q, write_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mdout_q, mdout_d;

  logic [31:0] load_data;
  logic [31:0] merged;
  size_e       req_size;

  assign req_size = size_e'(cpu.ReqSize);

  lsu_align u_align (
    .rd_word_i   (mem.MemDataIn),
    .wdata_i     (wdata_q),
    .off_i       (off_q),
    .size_i      (size_q),
    .signed_i    (signed_q),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    size_d   = size_q;
    signed_d = signed_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    maddr_d  = maddr_q;
    mdout_d  = mdout_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu.ReqValid) begin
          off_d    = cpu.ReqAddr[1:0];
          size_d   = req_size;
          signed_d = cpu.ReqSigned;
          write_d  = cpu.ReqWrite;
          wdata_d  = cpu.ReqWData[15:0];
          maddr_d  = {cpu.ReqAddr[31:2], 2'b00};
          if (req_error(req_size, cpu.ReqAddr, MEM_BYTES)) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else if (cpu.ReqWrite && req_size == SZ_WORD) begin
            state_d = ST_WRITE;
            mdout_d = cpu.ReqWData;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (write_q) begin
          state_d = ST_WRITE;
          mdout_d = merged;
        end else begin
          state_d = ST_RESP;
          rdata_d = load_data;
          err_d   = 1'b0;
        end
      end
      ST_WRITE: begin
        state_d = ST_RESP;
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    // Strobes come straight from flops so the memory never sees decode glitches.
    rd_d  = (state_d == ST_READ);
    wr_d  = (state_d == ST_WRITE);
    vld_d = (state_d == ST_RESP);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      off_q    <= 2'b00;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= 16'h0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      maddr_q  <= 32'h0;
      mdout_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      mdout_q  <= mdout_d;
    end
  end

  assign cpu.ReqReady   = (state_q == ST_IDLE);
  assign cpu.RespValid  = vld_q;
  assign cpu.RespRData  = rdata_q;
  assign cpu.RespErr    = err_q;
  assign mem.MemRD      = rd_q;
  assign mem.MemWR      = wr_q;
  assign mem.MemAddr    = maddr_q;
  assign mem.MemDataOut = mdout_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit against a big-endian word memory model.
// Expected responses are queued at acceptance and retired on each RespValid pulse.
module tb_load_store_unit;

  logic clk;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] wdat;
    logic [31:0] addr;
    int          acc;
  } exp_t;

  exp_t sb[$];

  lsu_cpu_if cpu_bus ();
  lsu_mem_if mem_bus ();

  load_store_unit #(.MEM_BYTES(512)) dut (
    .CLK   (clk),
    .Reset (rst),
    .cpu   (cpu_bus),
    .mem   (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: combinational read, write on negedge, preloaded on the first negedge.
  logic [31:0] mem [0:127];
  bit          mem_loaded = 1'b0;
  assign mem_bus.MemDataIn = mem[mem_bus.MemAddr[8:2]];
  always @(negedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h8012_34F5;
      mem[8] <= 32'h1122_3344;
      mem_loaded <= 1'b1;
    end else if (mem_bus.MemWR) begin
      mem[mem_bus.MemAddr[8:2]] <= mem_bus.MemDataOut;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Monitor: counts memory strobes since the last response and retires scoreboard entries.
  int          rd_cyc = 0;
  int          wr_cyc = 0;
  logic [31:0] seen_addr = 32'h0;
  logic [31:0] seen_wdat = 32'h0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      rd_cyc = 0;
      wr_cyc = 0;
    end else begin
      if (mem_bus.MemRD && mem_bus.MemWR) check("rd_wr_exclusive", mem_bus.MemWR, 32'd0);
      if (mem_bus.MemRD) begin
        rd_cyc++;
        seen_addr = mem_bus.MemAddr;
      end
      if (mem_bus.MemWR) begin
        wr_cyc++;
        seen_addr = mem_bus.MemAddr;
        seen_wdat = mem_bus.MemDataOut;
      end
      if (cpu_bus.RespValid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", cpu_bus.RespValid, 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_rdata", cpu_bus.RespRData, e.rdata);
          check("resp_err", cpu_bus.RespErr, e.err);
          check("resp_latency", cyc - e.acc, e.lat);
          check("memrd_cycles", rd_cyc, e.rd);
          check("memwr_cycles", wr_cyc, e.wr);
          if (e.rd + e.wr > 0) check("mem_addr", seen_addr, e.addr);
          if (e.wr > 0) check("mem_wdata", seen_wdat, e.wdat);
        end
        rd_cyc = 0;
        wr_cyc = 0;
      end
    end
  end

  // ex_data: load result for loads, word written to memory for stores.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ex_data, input logic ex_err,
                       input bit hold, input bit push);
    exp_t e;
    bit   ok;
    e.rdata = (wr || ex_err) ? 32'h0 : ex_data;
    e.err   = ex_err;
    e.wdat  = ex_data;
    e.addr  = {a[31:2], 2'b00};
    if (ex_err)              begin e.lat = 1; e.rd = 0; e.wr = 0; end
    else if (!wr)            begin e.lat = 2; e.rd = 1; e.wr = 0; end
    else if (sz == 2'b10)    begin e.lat = 2; e.rd = 0; e.wr = 1; end
    else                     begin e.lat = 3; e.rd = 1; e.wr = 1; end
    @(negedge clk);
    cpu_bus.ReqWrite  = wr;
    cpu_bus.ReqSize   = sz;
    cpu_bus.ReqSigned = sg;
    cpu_bus.ReqAddr   = a;
    cpu_bus.ReqWData  = wd;
    cpu_bus.ReqValid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cpu_bus.ReqReady) begin
        ok    = 1'b1;
        e.acc = cyc;
        if (push) sb.push_back(e);
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("req_accept_timeout", cpu_bus.ReqReady, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) cpu_bus.ReqValid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drain", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    cpu_bus.ReqValid  = 1'b0;
    cpu_bus.ReqWrite  = 1'b0;
    cpu_bus.ReqSize   = 2'b00;
    cpu_bus.ReqSigned = 1'b0;
    cpu_bus.ReqAddr   = 32'h0;
    cpu_bus.ReqWData  = 32'h0;
    #3;
    check("rst_ready", cpu_bus.ReqReady, 32'd1);
    check("rst_memrd", mem_bus.MemRD, 32'd0);
    check("rst_memwr", mem_bus.MemWR, 32'd0);
    check("rst_respvalid", cpu_bus.RespValid, 32'd0);
    check("rst_resperr", cpu_bus.RespErr, 32'd0);
    check("rst_rdata", cpu_bus.RespRData, 32'd0);
    check("rst_memaddr", mem_bus.MemAddr, 32'd0);
    check("rst_memdout", mem_bus.MemDataOut, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Loads from the preloaded word 80 12 34 F5 at 0x10.
    issue(0, 2'b10, 0, 32'h10, 0, 32'h8012_34F5, 0, 0, 1);
    issue(0, 2'b00, 1, 32'h10, 0, 32'hFFFF_FF80, 0, 0, 1);
    issue(0, 2'b00, 0, 32'h13, 0, 32'h0000_00F5, 0, 0, 1);
    issue(0, 2'b01, 1, 32'h10, 0, 32'hFFFF_8012, 0, 0, 1);
    issue(0, 2'b01, 0, 32'h12, 0, 32'h0000_34F5, 0, 0, 1);
    issue(0, 2'b00, 1, 32'h13, 0, 32'hFFFF_FFF5, 0, 0, 1);
    issue(0, 2'b00, 1, 32'h11, 0, 32'h0000_0012, 0, 0, 1);
    issue(0, 2'b01, 1, 32'h12, 0, 32'h0000_34F5, 0, 0, 1);

    // Sub-word and word stores, each read back.
    issue(1, 2'b00, 0, 32'h11, 32'h0000_00AB, 32'h80AB_34F5, 0, 0, 1);
    issue(0, 2'b10, 0, 32'h10, 0, 32'h80AB_34F5, 0, 0, 1);
    drain();
    repeat (3) @(negedge clk);
    check("rdata_hold", cpu_bus.RespRData, 32'h80AB_34F5);
    check("valid_idle", cpu_bus.RespValid, 32'd0);
    issue(1, 2'b01, 0, 32'h22, 32'hFFFF_BEEF, 32'h1122_BEEF, 0, 0, 1);
    issue(0, 2'b10, 0, 32'h20, 0, 32'h1122_BEEF, 0, 0, 1);
    issue(1, 2'b10, 0, 32'h24, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 0, 1);
    issue(0, 2'b10, 1, 32'h24, 0, 32'hCAFE_F00D, 0, 0, 1);

    // Rejected accesses.
    issue(0, 2'b10, 0, 32'h12,  0, 32'h0, 1, 0, 1);
    issue(1, 2'b01, 0, 32'h11,  32'h1234, 32'h0, 1, 0, 1);
    issue(1, 2'b10, 0, 32'h200, 32'h1, 32'h0, 1, 0, 1);
    issue(0, 2'b11, 0, 32'h10,  0, 32'h0, 1, 0, 1);
    issue(0, 2'b00, 0, 32'h200, 0, 32'h0, 1, 0, 1);
    issue(0, 2'b00, 0, 32'h1FF, 0, 32'h0, 0, 0, 1);

    // ReqValid held high across two loads.
    issue(0, 2'b10, 0, 32'h20, 0, 32'h1122_BEEF, 0, 1, 1);
    issue(0, 2'b00, 0, 32'h13, 0, 32'h0000_00F5, 0, 0, 1);
    drain();

    // Reset while a word store sits in WRITE.
    issue(1, 2'b10, 0, 32'h28, 32'h5555_AAAA, 32'h5555_AAAA, 0, 0, 0);
    check("wr_before_reset", mem_bus.MemWR, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("wr_after_reset", mem_bus.MemWR, 32'd0);
    check("ready_after_reset", cpu_bus.ReqReady, 32'd1);
    check("valid_after_reset", cpu_bus.RespValid, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(0, 2'b10, 0, 32'h10, 0, 32'h80AB_34F5, 0, 0, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
